// File: rtl/fpmul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fpmul_pkg;

    // Operand classification; subnormals are folded into ZERO.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_t;

    // Bit positions inside the 3-bit flags vector {invalid, overflow, underflow}.
    localparam int FLG_INV = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UDF = 0;

    // Total encoded width: sign + exponent + stored mantissa.
    function automatic int fp_width(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Exponent bias 2^(exp_w-1)-1.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB set.
    // Returned zero-extended to 64 bits; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fpmul_rne_round.sv
// Round-to-nearest-even on a normalised mantissa, followed by the
// post-round exponent range checks. Purely combinational.
module fpmul_rne_round
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [MAN_W-1:0]        man,
    input  logic                    guard_bit,
    input  logic                    round_bit,
    input  logic                    sticky_bit,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [MAN_W-1:0]        man_out,
    output logic [EXP_W-1:0]        exp_out,
    output logic                    ovf,
    output logic                    udf
);

    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
    localparam logic signed [EW2-1:0] ZERO_S  = '0;
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    logic                  inc;
    logic [MAN_W:0]        sum;
    logic signed [EW2-1:0] exp_adj;

    // Increment on guard when the tail is above half or the tie breaks to even;
    // a carry out of the mantissa leaves the low bits zero and bumps the exponent.
    always_comb begin
        inc     = guard_bit && (round_bit || sticky_bit || man[0]);
        sum     = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        man_out = sum[MAN_W-1:0];
        exp_adj = sum[MAN_W] ? (exp_in + ONE_S) : exp_in;
        exp_out = exp_adj[EXP_W-1:0];
        ovf     = (exp_adj >= EXP_MAX);
        udf     = (exp_adj <= ZERO_S);
    end

endmodule

// File: rtl/fpmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake,
// RNE rounding, special-operand handling and exception flags.
// S1: operand register + classify, S2: exponent sum + mantissa product,
// S3: normalise, round, special-case select (registered outputs).
module fpmul_pipe
    import fpmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int W    = fp_width(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [2:0]   flags
);

    localparam int EW2  = EXP_W + 2;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MW1;
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic signed [EW2-1:0] BIAS_S   = EW2'(BIAS);
    localparam logic signed [EW2-1:0] ONE_S    = EW2'(1);
    localparam logic [W-1:0]          QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;

    // Classify one encoded operand; subnormals flush to ZERO.
    function automatic fp_class_t classify(input logic [W-1:0] v);
        fp_class_t c;
        if (v[W-2 -: EXP_W] == '0)
            c = ZERO;
        else if (v[W-2 -: EXP_W] == EXP_ONES)
            c = (v[MAN_W-1:0] == '0) ? INF : NAN;
        else
            c = NORM;
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: the whole pipe advances together; a full S3 that the
    // consumer is not taking freezes every stage.
    // ------------------------------------------------------------------
    logic       adv;
    logic [3:1] vld_pipe;

    assign adv       = !vld_pipe[3] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[3];

    // Valid bits shift one stage per advance; bubbles travel with the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[2:1], in_valid};
    end

    // ------------------------------------------------------------------
    // S1: operand capture and classification
    // ------------------------------------------------------------------
    logic [W-1:0] s1_a, s1_b;
    fp_class_t    s1_ca, s1_cb;

    // Register operands together with their class.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_ca <= ZERO;
            s1_cb <= ZERO;
        end else if (adv) begin
            s1_a  <= x1;
            s1_b  <= x2;
            s1_ca <= classify(x1);
            s1_cb <= classify(x2);
        end
    end

    // ------------------------------------------------------------------
    // S2: exponent sum and full mantissa product
    // ------------------------------------------------------------------
    logic signed [EW2-1:0] exp_sum;
    logic [PW-1:0]         prod;

    // Unbiased sum kept signed and two bits wider so under/overflow stay visible.
    always_comb begin
        exp_sum = $signed({2'b00, s1_a[W-2 -: EXP_W]})
                + $signed({2'b00, s1_b[W-2 -: EXP_W]})
                - BIAS_S;
        prod    = PW'({1'b1, s1_a[MAN_W-1:0]}) * PW'({1'b1, s1_b[MAN_W-1:0]});
    end

    logic                  s2_sign;
    fp_class_t             s2_ca, s2_cb;
    logic signed [EW2-1:0] s2_exp;
    logic [PW-1:0]         s2_prod;

    // Register sign, classes, exponent and product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_sign <= 1'b0;
            s2_ca   <= ZERO;
            s2_cb   <= ZERO;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else if (adv) begin
            s2_sign <= s1_a[W-1] ^ s1_b[W-1];
            s2_ca   <= s1_ca;
            s2_cb   <= s1_cb;
            s2_exp  <= exp_sum;
            s2_prod <= prod;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round, select
    // ------------------------------------------------------------------
    // nrm drops the leading one; its top MAN_W bits are the fraction,
    // followed by guard, round and the sticky tail.
    logic [PW-2:0]         nrm;
    logic signed [EW2-1:0] exp_n;
    logic [MAN_W-1:0]      frac;
    logic                  g_bit, r_bit, s_bit;

    // Product lies in [1,4): shift right by one when it reached 2.
    always_comb begin
        if (s2_prod[PW-1]) begin
            nrm   = s2_prod[PW-2:0];
            exp_n = s2_exp + ONE_S;
        end else begin
            nrm   = {s2_prod[PW-3:0], 1'b0};
            exp_n = s2_exp;
        end
        frac  = nrm[PW-2 -: MAN_W];
        g_bit = nrm[PW-2-MAN_W];
        r_bit = nrm[PW-3-MAN_W];
        s_bit = |nrm[PW-4-MAN_W:0];
    end

    logic [MAN_W-1:0] rnd_man;
    logic [EXP_W-1:0] rnd_exp;
    logic             rnd_ovf, rnd_udf;

    fpmul_rne_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .man        (frac),
        .guard_bit  (g_bit),
        .round_bit  (r_bit),
        .sticky_bit (s_bit),
        .exp_in     (exp_n),
        .man_out    (rnd_man),
        .exp_out    (rnd_exp),
        .ovf        (rnd_ovf),
        .udf        (rnd_udf)
    );

    logic [W-1:0] res_y;
    logic [2:0]   res_flags;

    // Special operands override the datapath in priority order, then the
    // post-round range checks saturate to Inf or flush to zero.
    always_comb begin
        res_y     = '0;
        res_flags = '0;
        if (s2_ca == NAN || s2_cb == NAN) begin
            res_y = QNAN;
        end else if ((s2_ca == INF && s2_cb == ZERO) ||
                     (s2_ca == ZERO && s2_cb == INF)) begin
            res_y              = QNAN;
            res_flags[FLG_INV] = 1'b1;
        end else if (s2_ca == INF || s2_cb == INF) begin
            res_y = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_ca == ZERO || s2_cb == ZERO) begin
            res_y = {s2_sign, {(W-1){1'b0}}};
        end else if (rnd_ovf) begin
            res_y              = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            res_flags[FLG_OVF] = 1'b1;
        end else if (rnd_udf) begin
            res_y              = {s2_sign, {(W-1){1'b0}}};
            res_flags[FLG_UDF] = 1'b1;
        end else begin
            res_y = {s2_sign, rnd_exp, rnd_man};
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y     <= '0;
            flags <= '0;
        end else if (adv) begin
            y     <= res_y;
            flags <= res_flags;
        end
    end

endmodule

// File: tb/tb_fpmul_pipe.sv
// Self-checking bench for fpmul_pipe: bfloat16 instance driven through a
// scoreboard, plus a half-precision instance for the parameter sweep.
module tb_fpmul_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // bfloat16 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] x1, x2, y;
    logic [2:0]  flags;

    // half-precision instance
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_x1, h_x2, h_y;
    logic [2:0]  h_flags;

    fpmul_pipe #(.EXP_W(8), .MAN_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    fpmul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .x1        (h_x1),
        .x2        (h_x2),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .y         (h_y),
        .flags     (h_flags)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [18:0] sb[$];   // expected {y, flags}

    // Directed vectors: operands and expected {y, flags}
    logic [15:0] d_a [0:7] = '{16'h3F81, 16'h3F83, 16'h7F80, 16'hFF80,
                               16'h7FC1, 16'h7F00, 16'h0080, 16'h8080};
    logic [15:0] d_b [0:7] = '{16'h3FC0, 16'h3FC0, 16'h0000, 16'h4000,
                               16'h3F80, 16'h4000, 16'h3F00, 16'h3F00};
    logic [18:0] d_e [0:7] = '{{16'h3FC2, 3'b000}, {16'h3FC4, 3'b000},
                               {16'h7FC0, 3'b100}, {16'hFF80, 3'b000},
                               {16'h7FC0, 3'b000}, {16'h7F80, 3'b010},
                               {16'h0000, 3'b001}, {16'h8000, 3'b001}};

    // Backpressure vectors: 1*1, 2*2, 1.5*2, 3*3, -2*0.5
    logic [15:0] bp_a [0:4] = '{16'h3F80, 16'h4000, 16'h3FC0, 16'h4040, 16'hC000};
    logic [15:0] bp_b [0:4] = '{16'h3F80, 16'h4000, 16'h4000, 16'h4040, 16'h3F00};
    logic [18:0] bp_e [0:4] = '{{16'h3F80, 3'b000}, {16'h4080, 3'b000},
                                {16'h4040, 3'b000}, {16'h4110, 3'b000},
                                {16'hBF80, 3'b000}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: compare every result the consumer takes.
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_output: observed %h expected none", {y, flags});
            end else begin
                chk("result", 32'({y, flags}), 32'(sb.pop_front()));
            end
        end
    end

    // Offer one operand pair until accepted (bounded), recording its result.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [18:0] e);
        int n;
        x1 = a; x2 = b; in_valid = 1'b1; n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Single transfer with latency check; out_ready assumed high.
    task automatic lat_test(input string pfx, input logic [15:0] a, input logic [15:0] b,
                            input logic [18:0] e);
        chk({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
        x1 = a; x2 = b; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;            // transfer edge
        in_valid = 1'b0;
        chk({pfx, "_edge1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({pfx, "_edge2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({pfx, "_edge3"}, 32'(out_valid), 32'd1);
        @(negedge clk);                // monitor consumes here
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        rst = 1'b0; in_valid = 1'b0; x1 = '0; x2 = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_x1 = '0; h_x2 = '0; h_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic multiply with latency
        lat_test("basic", 16'h3FC0, 16'h4000, {16'h4040, 3'b000});

        // Back-to-back directed stream: RNE ties, specials, range
        for (int i = 0; i < 8; i++) send(d_a[i], d_b[i], d_e[i]);
        drain();

        // Backpressure: consumer stalled, five pairs offered
        out_ready = 1'b0; idx = 0;
        x1 = bp_a[0]; x2 = bp_b[0]; in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready && idx < 5) begin
                sb.push_back(bp_e[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 5) begin x1 = bp_a[idx]; x2 = bp_b[idx]; end
            else in_valid = 1'b0;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(posedge clk); #1;
        chk("bp_y_hold", 32'({y, flags}), 32'(bp_e[0]));
        chk("bp_still_stalled", 32'(in_ready), 32'd0);

        // Release: one result out and one pair in per cycle
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_stream_valid", 32'(out_valid), 32'd1);
            if (in_valid && in_ready && idx < 5) begin
                sb.push_back(bp_e[idx]);
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 5) begin x1 = bp_a[idx]; x2 = bp_b[idx]; end
            else in_valid = 1'b0;
        end
        chk("bp_all_accepted", 32'(idx), 32'd5);
        @(negedge clk);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with two results in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h3FC0, 16'h4000, {16'h4040, 3'b000});
        send(16'h4000, 16'h4000, {16'h4080, 3'b000});
        @(posedge clk); #1;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        chk("mid_pre_y", 32'(y), 32'h4040);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_flags", 32'(flags), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        lat_test("after_rst", 16'h3F83, 16'h3FC0, {16'h3FC4, 3'b000});
        chk("after_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Half-precision instance
        h_x1 = 16'h3C00; h_x2 = 16'h4000; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("h_basic_valid", 32'(h_out_valid), 32'd1);
        chk("h_basic_res", 32'({h_y, h_flags}), 32'({16'h4000, 3'b000}));
        h_x1 = 16'h7BFF; h_x2 = 16'h4000; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("h_ovf_valid", 32'(h_out_valid), 32'd1);
        chk("h_ovf_res", 32'({h_y, h_flags}), 32'({16'h7C00, 3'b010}));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
